// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // Bit offset of port `port` in a flattened bus of `width`-bit lanes.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: tracks destinations issued but not yet
// written back, flags busy read ports and gates new reservations.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rf_w,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  input  logic                    iss_v,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    flush,
  output logic [NREAD-1:0]        rbusy,
  output logic                    iss_rdy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             iss_acc;
  logic [ADDR_W-1:0] ra;

  assign iss_rdy = (iss_addr == ADDR_W'(REG_ZERO))
                 || !pend_q[iss_addr]
                 || (rf_w && waddr == iss_addr);

  assign iss_acc = iss_v && iss_rdy && !flush;

  always_comb begin
    rbusy = '0;
    ra    = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra = raddr[port_lsb(i, ADDR_W) +: ADDR_W];
      rbusy[i] = pend_q[ra]
               && !(rf_w && waddr == ra)
               && ra != ADDR_W'(REG_ZERO);
    end
  end

  // Issue wins over write-back so a same-cycle reissue keeps ownership.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (iss_acc && iss_addr == ADDR_W'(r))
          pend_d[r] = 1'b1;
        else if (rf_w && waddr == ADDR_W'(r))
          pend_d[r] = 1'b0;
      end
    end
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with write-through bypass, hardwired r0,
// debug taps and an integrated write-pending scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2,
  parameter int DBG0   = 11,
  parameter int DBG1   = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rf_w,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    iss_v,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic                    iss_rdy,
  input  logic                    flush,
  output logic [DATA_W-1:0]       dbg_reg0,
  output logic [DATA_W-1:0]       dbg_reg1
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [31:0] DBG0_W = DBG0;
  localparam logic [31:0] DBG1_W = DBG1;
  localparam logic [ADDR_W-1:0] DBG0_A = DBG0_W[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] DBG1_A = DBG1_W[ADDR_W-1:0];

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wr_en_d;
  logic [ADDR_W-1:0] ra;

  assign wr_en_d = rf_w && waddr != ADDR_W'(REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++)
        regs_q[r] <= '0;
    end else if (wr_en_d) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    ra    = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra = raddr[port_lsb(i, ADDR_W) +: ADDR_W];
      if (ra == ADDR_W'(REG_ZERO))
        rdata[port_lsb(i, DATA_W) +: DATA_W] = '0;
      else if (rf_w && waddr == ra)
        rdata[port_lsb(i, DATA_W) +: DATA_W] = wdata;
      else
        rdata[port_lsb(i, DATA_W) +: DATA_W] = regs_q[ra];
    end
  end

  // Taps show committed array state only, never the bypass path.
  assign dbg_reg0 = regs_q[DBG0_A];
  assign dbg_reg1 = regs_q[DBG1_A];

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rf_w     (rf_w),
    .waddr    (waddr),
    .raddr    (raddr),
    .iss_v    (iss_v),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rbusy    (rbusy),
    .iss_rdy  (iss_rdy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb: bypass, r0, scoreboard, flush, reset.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_w;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        iss_v;
  logic [4:0]  iss_addr;
  logic        iss_rdy;
  logic        flush;
  logic [31:0] dbg_reg0;
  logic [31:0] dbg_reg1;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_W (32),
    .ADDR_W (5),
    .NREAD  (2),
    .DBG0   (11),
    .DBG1   (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rf_w     (rf_w),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .iss_v    (iss_v),
    .iss_addr (iss_addr),
    .iss_rdy  (iss_rdy),
    .flush    (flush),
    .dbg_reg0 (dbg_reg0),
    .dbg_reg1 (dbg_reg1)
  );

  typedef struct {
    logic        rst;
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iv;
    logic [4:0]  ia;
    logic        fl;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic        er;
    logic [31:0] ed0;
    logic [31:0] ed1;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rf_w = 0; waddr = 0; wdata = 0; raddr = 0;
    iss_v = 0; iss_addr = 0; flush = 0;

    //        rst w wa  wd            ra0 ra1 iv ia fl  e0            e1            eb     er ed0    ed1
    vq.push_back('{0,1,5, 32'hDEADBEEF,5, 0, 0, 0, 0, 32'hDEADBEEF,32'h0,        2'b00,1,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       5, 0, 0, 0, 0, 32'hDEADBEEF,32'h0,        2'b00,1,32'h0, 32'h0});
    vq.push_back('{0,1,0, 32'h1234,    0, 5, 0, 0, 0, 32'h0,       32'hDEADBEEF,2'b00,1,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       0, 7, 1, 7, 0, 32'h0,       32'h0,        2'b00,1,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       0, 7, 1, 7, 0, 32'h0,       32'h0,        2'b10,0,32'h0, 32'h0});
    vq.push_back('{0,1,7, 32'h55,      0, 7, 0, 7, 0, 32'h0,       32'h55,       2'b00,1,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       0, 7, 0, 7, 0, 32'h0,       32'h55,       2'b00,1,32'h0, 32'h0});
    vq.push_back('{0,1,9, 32'hAA,      9, 0, 1, 9, 0, 32'hAA,      32'h0,        2'b00,1,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       9, 0, 0, 9, 0, 32'hAA,      32'h0,        2'b01,0,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       3, 0, 1, 3, 0, 32'h0,       32'h0,        2'b00,1,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       3, 0, 1, 4, 0, 32'h0,       32'h0,        2'b01,1,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       4, 3, 1, 11,0, 32'h0,       32'h0,        2'b11,1,32'h0, 32'h0});
    vq.push_back('{0,1,11,32'h77,      11,4, 0, 11,1, 32'h77,      32'h0,        2'b10,1,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       3, 4, 0, 9, 0, 32'h0,       32'h0,        2'b00,1,32'h77,32'h0});
    vq.push_back('{0,0,0, 32'h0,       9, 11,0, 11,0, 32'hAA,      32'h77,       2'b00,1,32'h77,32'h0});
    vq.push_back('{0,1,12,32'h12,      12,0, 0, 0, 0, 32'h12,      32'h0,        2'b00,1,32'h77,32'h0});
    vq.push_back('{0,0,0, 32'h0,       12,0, 1, 12,0, 32'h12,      32'h0,        2'b00,1,32'h77,32'h12});
    vq.push_back('{0,0,0, 32'h0,       12,0, 0, 12,0, 32'h12,      32'h0,        2'b01,0,32'h77,32'h12});
    vq.push_back('{1,1,12,32'h99,      12,0, 1, 12,1, 32'h99,      32'h0,        2'b00,1,32'h77,32'h12});
    vq.push_back('{0,0,0, 32'h0,       12,5, 0, 12,0, 32'h0,       32'h0,        2'b00,1,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       0, 11,1, 0, 0, 32'h0,       32'h0,        2'b00,1,32'h0, 32'h0});
    vq.push_back('{0,0,0, 32'h0,       0, 0, 0, 0, 0, 32'h0,       32'h0,        2'b00,1,32'h0, 32'h0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 32; r++) begin
      raddr = {5'(31 - r), 5'(r)};
      iss_addr = 5'(r);
      #1;
      chk($sformatf("rst_rd0_r%0d", r), rdata[31:0], 32'h0);
      chk($sformatf("rst_rd1_r%0d", r), rdata[63:32], 32'h0);
      chk($sformatf("rst_busy_r%0d", r), 32'(rbusy), 32'h0);
      chk($sformatf("rst_rdy_r%0d", r), 32'(iss_rdy), 32'h1);
    end
    chk("rst_dbg0", dbg_reg0, 32'h0);
    chk("rst_dbg1", dbg_reg1, 32'h0);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      rst = vq[k].rst; rf_w = vq[k].w; waddr = vq[k].wa;
      wdata = vq[k].wd; raddr = {vq[k].ra1, vq[k].ra0};
      iss_v = vq[k].iv; iss_addr = vq[k].ia; flush = vq[k].fl;
      #1;
      chk($sformatf("v%0d_rdata0", k), rdata[31:0], vq[k].e0);
      chk($sformatf("v%0d_rdata1", k), rdata[63:32], vq[k].e1);
      chk($sformatf("v%0d_rbusy", k), 32'(rbusy), 32'(vq[k].eb));
      chk($sformatf("v%0d_iss_rdy", k), 32'(iss_rdy), 32'(vq[k].er));
      chk($sformatf("v%0d_dbg0", k), dbg_reg0, vq[k].ed0);
      chk($sformatf("v%0d_dbg1", k), dbg_reg1, vq[k].ed1);
    end

    // Reissue held across a write-back: r20 pending, write and reissue
    // in one cycle, then the register stays owned by the new issue.
    @(negedge clk);
    rst = 0; rf_w = 0; flush = 0; iss_v = 1; iss_addr = 5'd20;
    raddr = {5'd0, 5'd20};
    @(negedge clk);
    #1;
    chk("seq_pend20", 32'(rbusy), 32'h1);
    chk("seq_rdy20_blk", 32'(iss_rdy), 32'h0);
    rf_w = 1; waddr = 5'd20; wdata = 32'hCAFE0020;
    #1;
    chk("seq_rdy20_wb", 32'(iss_rdy), 32'h1);
    chk("seq_byp20", rdata[31:0], 32'hCAFE0020);
    @(negedge clk);
    rf_w = 0; iss_v = 0;
    #1;
    chk("seq_owned20", 32'(rbusy), 32'h1);
    chk("seq_arr20", rdata[31:0], 32'hCAFE0020);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
